// File: rtl/reg_bus_pkg.sv
// Shared types for the valid/ready register-access bus: responder states,
// request/response records at default widths, and default width constants.
package reg_bus_pkg;

    localparam int ADDR_W_DEF      = 8;
    localparam int DATA_W_DEF      = 32;
    localparam int NUM_REGS_DEF    = 16;
    localparam int WAIT_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } rsp_state_e;

    typedef struct packed {
        logic                      write;
        logic [ADDR_W_DEF-1:0]     addr;
        logic [DATA_W_DEF-1:0]     wdata;
        logic [DATA_W_DEF/8-1:0]   be;
    } req_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] rdata;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/reg_bus_if.sv
// Request and response channels of the register-access bus.
interface reg_bus_if
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/reg_bus_regfile.sv
// NUM_REGS x DATA_W register storage: byte-enable write port and a
// combinational read port sharing one address.
module reg_bus_regfile #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata
);
    localparam int BE_W = DATA_W / 8;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (we) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (addr == ADDR_W'(r) && be[b])
                        regs[r][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Unimplemented addresses read as zero; the caller flags them as errors.
    always_comb begin
        rdata = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (addr == ADDR_W'(r))
                rdata = regs[r];
        end
    end

endmodule

// File: rtl/reg_bus_responder.sv
// Register-bus responder: accepts one request, holds it WAIT_CYCLES wait
// states, commits it once on entry to RESP and holds the response until taken.
module reg_bus_responder
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    reg_bus_if.slave  bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    typedef struct packed {
        logic                write;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [BE_W-1:0]     be;
    } req_l_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_l_t;

    rsp_state_e         state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    req_l_t             req_q, cur_req;
    rsp_l_t             rsp_q;
    logic               latch, commit, addr_err;
    logic [DATA_W-1:0]  rf_rdata;

    // With zero wait states the commit happens on the accept edge, so the
    // live bus request is used directly instead of the latched copy.
    always_comb begin
        if (state_q == IDLE)
            cur_req = '{write: bus.req_write, addr: bus.req_addr,
                        wdata: bus.req_wdata, be: bus.req_be};
        else
            cur_req = req_q;
    end

    // Extra top bit keeps the compare correct when NUM_REGS == 2**ADDR_W.
    assign addr_err = {1'b0, cur_req.addr} >= NUM_REGS_W;

    reg_bus_regfile #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit && cur_req.write && !addr_err),
        .addr  (cur_req.addr),
        .wdata (cur_req.wdata),
        .be    (cur_req.be),
        .rdata (rf_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        cnt_d   = 8'(WAIT_CYCLES - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch)
                req_q <= cur_req;
            if (commit) begin
                rsp_q.err   <= addr_err;
                rsp_q.rdata <= (cur_req.write || addr_err) ? '0 : rf_rdata;
            end else if (state_q == RESP && bus.rsp_ready) begin
                rsp_q <= '0;
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_q.rdata;
    assign bus.rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_reg_bus_responder.sv
// Scoreboard bench: two responders (WAIT_CYCLES=2 and 0); expected responses
// are queued at accept and checked by per-bus monitors on the rsp handshake.
module tb_reg_bus_responder;
    import reg_bus_pkg::*;

    typedef struct {
        rsp_t rsp;
        int   acc;
    } sb_t;

    logic clk = 1'b0;
    logic rst0_n, rst2_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    sb_t  q0[$];
    sb_t  q2[$];
    sb_t  e0, e2;
    logic pv0 = 1'b0;
    logic pv2 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_bus_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();
    reg_bus_if #(.ADDR_W(8), .DATA_W(32)) bus2 ();

    reg_bus_responder #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(0))
        u_dut0 (.clk(clk), .rst_n(rst0_n), .bus(bus0.slave));
    reg_bus_responder #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .WAIT_CYCLES(2))
        u_dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2.slave));

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic drive(int sel, logic v, logic wr, logic [7:0] a, logic [31:0] d, logic [3:0] be);
        if (sel == 0) begin
            bus0.req_valid = v; bus0.req_write = wr; bus0.req_addr = a;
            bus0.req_wdata = d; bus0.req_be = be;
        end else begin
            bus2.req_valid = v; bus2.req_write = wr; bus2.req_addr = a;
            bus2.req_wdata = d; bus2.req_be = be;
        end
    endtask

    function automatic logic rdy(int sel);
        return (sel == 0) ? bus0.req_ready : bus2.req_ready;
    endfunction

    // Present a request, record its accept cycle T and queue the expected response.
    task automatic issue(int sel, logic wr, logic [7:0] a, logic [31:0] d, logic [3:0] be,
                         logic [31:0] exp_d, logic exp_e);
        sb_t e;
        bit  ok = 0;
        @(posedge clk); #1;
        drive(sel, 1'b1, wr, a, d, be);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (rdy(sel)) begin
                ok = 1;
                e.rsp.rdata = exp_d;
                e.rsp.err   = exp_e;
                e.acc       = cyc;
                if (sel == 0) q0.push_back(e); else q2.push_back(e);
            end
        end
        if (!ok) chk("accept timeout", 0, 1);
        @(posedge clk); #1;
        drive(sel, 1'b0, 'x, 'x, 'x, 'x);
    endtask

    task automatic wait_idle(int sel);
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = rdy(sel) && ((sel == 0) ? q0.size() == 0 : q2.size() == 0);
        end
        if (!ok) chk("drain timeout", 0, 1);
    endtask

    // Hold the response for 10 cycles, then release it and expect IDLE next cycle.
    task automatic stall10(logic [31:0] exp_d);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus2.rsp_valid;
        end
        if (!seen) chk("stall rsp timeout", 0, 1);
        for (int i = 0; i < 10; i++) begin
            chk("stall rsp_valid", bus2.rsp_valid, 1);
            chk("stall req_ready", bus2.req_ready, 0);
            chk("stall rdata", bus2.rsp_rdata, exp_d);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle after handshake req_ready", bus2.req_ready, 1);
        chk("idle after handshake rsp_valid", bus2.rsp_valid, 0);
        chk("idle after handshake rdata clr", bus2.rsp_rdata, 0);
    endtask

    always @(negedge clk) begin
        if (bus0.rsp_valid && !pv0) begin
            if (q0.size() == 0) chk("dut0 unexpected rsp", 1, 0);
            else chk("dut0 latency", cyc, q0[0].acc + 1);
        end
        if (bus0.rsp_valid && bus0.rsp_ready && q0.size() > 0) begin
            e0 = q0.pop_front();
            chk("dut0 rdata", bus0.rsp_rdata, e0.rsp.rdata);
            chk("dut0 err", bus0.rsp_err, e0.rsp.err);
        end
        pv0 <= bus0.rsp_valid;
    end

    always @(negedge clk) begin
        if (bus2.rsp_valid && !pv2) begin
            if (q2.size() == 0) chk("dut2 unexpected rsp", 1, 0);
            else chk("dut2 latency", cyc, q2[0].acc + 3);
        end
        if (bus2.rsp_valid && bus2.rsp_ready && q2.size() > 0) begin
            e2 = q2.pop_front();
            chk("dut2 rdata", bus2.rsp_rdata, e2.rsp.rdata);
            chk("dut2 err", bus2.rsp_err, e2.rsp.err);
        end
        pv2 <= bus2.rsp_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0_n = 1'b0;
        rst2_n = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        drive(2, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        bus0.rsp_ready = 1'b1;
        bus2.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst0_n = 1'b1;
        rst2_n = 1'b1;
        @(negedge clk);
        chk("reset req_ready", bus2.req_ready, 1);
        chk("reset rsp_valid", bus2.rsp_valid, 0);
        chk("reset rsp_rdata", bus2.rsp_rdata, 0);
        chk("reset rsp_err", bus2.rsp_err, 0);
        chk("reset dut0 req_ready", bus0.req_ready, 1);

        // WAIT_CYCLES=2: basic reads/writes, byte enables, out-of-range
        issue(2, 1'b0, 8'd5,   32'h0,         4'hF, 32'h0000_0000, 1'b0);
        issue(2, 1'b1, 8'd3,   32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0);
        issue(2, 1'b0, 8'd3,   32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0);
        issue(2, 1'b1, 8'd7,   32'h1122_3344, 4'hF, 32'h0,         1'b0);
        issue(2, 1'b1, 8'd7,   32'hAABB_CCDD, 4'h5, 32'h0,         1'b0);
        issue(2, 1'b0, 8'd7,   32'h0,         4'h0, 32'h11BB_33DD, 1'b0);
        issue(2, 1'b1, 8'd16,  32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1);
        issue(2, 1'b0, 8'd16,  32'h0,         4'hF, 32'h0,         1'b1);
        issue(2, 1'b0, 8'd255, 32'h0,         4'hF, 32'h0,         1'b1);
        issue(2, 1'b0, 8'd0,   32'h0,         4'hF, 32'h0,         1'b0);
        issue(2, 1'b0, 8'd15,  32'h0,         4'hF, 32'h0,         1'b0);
        wait_idle(2);

        // Backpressure on a partial write, then on a read of the same register
        bus2.rsp_ready = 1'b0;
        issue(2, 1'b1, 8'd10, 32'h1234_5678, 4'h3, 32'h0, 1'b0);
        stall10(32'h0);
        bus2.rsp_ready = 1'b0;
        issue(2, 1'b0, 8'd10, 32'h0, 4'hF, 32'h0000_5678, 1'b0);
        stall10(32'h0000_5678);
        wait_idle(2);

        // WAIT_CYCLES=0: single-cycle latency, then reset while holding RESP
        issue(0, 1'b1, 8'd0, 32'h1234_5678, 4'hF, 32'h0,         1'b0);
        issue(0, 1'b0, 8'd0, 32'h0,         4'hF, 32'h1234_5678, 1'b0);
        wait_idle(0);
        bus0.rsp_ready = 1'b0;
        issue(0, 1'b1, 8'd0, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        chk("dut0 in RESP before reset", bus0.rsp_valid, 1);
        #2;
        rst0_n = 1'b0;
        #1;
        chk("dut0 rsp_valid async drop", bus0.rsp_valid, 0);
        chk("dut0 req_ready in reset", bus0.req_ready, 1);
        q0.delete();
        @(posedge clk); #1;
        rst0_n = 1'b1;
        bus0.rsp_ready = 1'b1;
        issue(0, 1'b0, 8'd0, 32'h0, 4'hF, 32'h0, 1'b0);
        wait_idle(0);

        chk("dut0 queue empty", q0.size(), 0);
        chk("dut2 queue empty", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_bus_responder.md
Name: reg_bus_responder

Overview:
- Responder (target) end of the team's simple valid/ready register-access bus. The UVM bench agent acts as initiator.
- Accepts one read or write request at a time and holds it for a programmable number of wait states.
- Returns a response on a separate valid/ready channel.
- Backs a small register file; it is the standard DUT the bench template is exercised against.

Parameters:
- ADDR_W, 8, request address width; the address is a word index.
- DATA_W, 32, data width; must be a multiple of 8.
- NUM_REGS, 16, number of implemented registers; must be at most 2**ADDR_W.
- WAIT_CYCLES, 2, wait states between request accept and response valid; legal range 0..255.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  register word index.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads.
- rsp_valid  out  1  response is valid.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range.

Behaviour:
- Reset (asynchronous assert, synchronous release of state via rst_n):
  - FSM goes to IDLE, wait counter = 0, all registers = 0.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid && req_ready (cycle T), latch write, addr, wdata and be.
  - If WAIT_CYCLES==0, go to RESP; otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; when it is 0, go to RESP.
- Entering RESP (single-cycle commit on the transition edge):
  - Error check: err = (addr >= NUM_REGS).
  - Write, no error: for each byte i with be[i]=1, reg[addr][8i+7:8i] <= wdata byte i. Bytes with be[i]=0 are unchanged.
  - Read, no error: rsp_rdata <= reg[addr], the value at commit time.
  - Error: no register update, rsp_rdata=0, rsp_err=1.
  - The write is committed exactly once, even if rsp_ready stalls.
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE, clear rsp_rdata and rsp_err to 0, and raise req_ready the next cycle.
- Latency: rsp_valid is first high at cycle T+1+WAIT_CYCLES.
- Throughput: at most one outstanding transaction. Minimum interval between accepts is WAIT_CYCLES+2 cycles with rsp_ready held at 1.
- req_ready is registered (state-derived) and has no combinational path from req_valid or rsp_ready.
- Width rule: the address compare is unsigned at ADDR_W bits. When NUM_REGS == 2**ADDR_W, no address can error.
- Reset mid-operation (in WAIT or RESP):
  - The transaction is dropped and rsp_valid falls immediately (async).
  - Registers clear, including one written by a commit in the same cycle.
  - The initiator must not expect a response.
- req_valid in WAIT/RESP: ignored; the initiator holds the request until req_ready.
- X on req_* while req_valid=0: ignored.

Decomposition:
- Shared package reg_bus_pkg:
  - responder state enum (IDLE, WAIT, RESP);
  - request struct {write, addr, wdata, be};
  - response struct {rdata, err};
  - default width localparams.
- The bench agent imports the same package.
- Sub-module reg_bus_regfile: NUM_REGS x DATA_W storage with async reset, byte-enable write port and combinational read port.
- The FSM, wait counter and response registers stay in reg_bus_responder.

Test Plan:
- Reset: assert rst_n=0 for 3 cycles, then release → req_ready=1, rsp_valid=0, and a read of addr 5 returns rdata=0x0000_0000, err=0.
- Write then read, WAIT_CYCLES=2: write addr 3, data 0xDEAD_BEEF, be=0xF, accepted at cycle T → rsp_valid rises at T+3 with err=0, rdata=0. A following read of addr 3 returns 0xDEAD_BEEF.
- Byte enables: addr 7 holds 0x1122_3344; write 0xAABB_CCDD with be=0x5 → read returns 0x11BB_33DD.
- Out of range, NUM_REGS=16: write addr 16 with 0xFFFF_FFFF, then read addr 16 → both responses have err=1, rdata=0. Read of addr 0 is unchanged.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP → rsp_valid stays 1, rdata stable, req_ready=0, and the write lands once. Raise rsp_ready → IDLE next cycle.
- WAIT_CYCLES=0 with reset mid-RESP:
  - Read accepted at T → rsp_valid at T+1.
  - Second write accepted, then rst_n asserted while in RESP → rsp_valid=0 immediately and register 0 reads 0 after release.
